// File: rtl/imm_pkg.sv
// Shared types and opcode constants for the pipelined immediate generator.
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5,
    IMM_Z    = 3'd6
  } imm_type_e;

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } skid_st_e;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle of imm_gen_pipe: input instruction stream, decoded output stream, flush.
interface imm_gen_pipe_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
);
  import imm_pkg::*;

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  imm_type_e        out_type;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output flush, in_valid, in_instr, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_type, out_tag
  );

  modport slave (
    input  flush, in_valid, in_instr, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_type, out_tag
  );

endinterface

// File: rtl/imm_decode.sv
// Combinational RV32I/RV64I immediate decoder; IMM_CSR_EN adds CSR zimm (IMM_Z) decoding.
module imm_decode
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o,
  output imm_type_e       type_o
);

  logic [31:0] imm32;

  always_comb begin
    imm32  = '0;
    type_o = IMM_NONE;
    case (instr_i[6:0])
      OPC_LOAD, OPC_OPIMM, OPC_JALR: begin
        imm32  = {{20{instr_i[31]}}, instr_i[31:20]};
        type_o = IMM_I;
      end
      OPC_OPIMM32: begin
        if (XLEN == 64) begin
          imm32  = {{20{instr_i[31]}}, instr_i[31:20]};
          type_o = IMM_I;
        end
      end
      OPC_STORE: begin
        imm32  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
        type_o = IMM_S;
      end
      OPC_BRANCH: begin
        imm32  = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
        type_o = IMM_B;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm32  = {instr_i[31:12], 12'b0};
        type_o = IMM_U;
      end
      OPC_JAL: begin
        imm32  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21],
                  1'b0};
        type_o = IMM_J;
      end
`ifdef IMM_CSR_EN
      OPC_SYSTEM: begin
        if (instr_i[14]) begin
          imm32  = {27'b0, instr_i[19:15]};
          type_o = IMM_Z;
        end else begin
          imm32  = {{20{instr_i[31]}}, instr_i[31:20]};
          type_o = IMM_I;
        end
      end
`endif
      default: ;
    endcase
    // imm32 is already sign-extended to 32 bits; widen to XLEN keeping the sign.
    imm_o = XLEN'($signed(imm32));
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: decode on input, then a 2-entry skid buffer (output + skid).
// Optional IMM_CSR_EN enables CSR zimm decoding in imm_decode.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
) (
  input logic          clk,
  input logic          rst_n,
  imm_gen_pipe_if.slave bus
);

  skid_st_e         state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic [XLEN-1:0]  dec_imm;
  imm_type_e        dec_type;
  logic             accept, drain, load_out, load_skid, move_skid;

  logic [XLEN-1:0]  out_imm_q, skid_imm_q;
  imm_type_e        out_type_q, skid_type_q;
  logic [TAG_W-1:0] out_tag_q, skid_tag_q;

  imm_decode #(
    .XLEN(XLEN)
  ) u_decode (
    .instr_i(bus.in_instr),
    .imm_o  (dec_imm),
    .type_o (dec_type)
  );

  assign accept = bus.in_valid & in_ready_q;
  assign drain  = (state_q != StEmpty) & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StEmpty;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StEmpty: if (accept) state_d = StOne;
      StOne: begin
        if (accept && !drain)      state_d = StTwo;
        else if (!accept && drain) state_d = StEmpty;
      end
      StTwo:   if (drain) state_d = StOne;
      default: state_d = StEmpty;
    endcase
    if (bus.flush) state_d = StEmpty;
    in_ready_d = (state_d != StTwo);
  end

  always_comb begin
    load_out  = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    case (state_q)
      StEmpty: load_out = accept;
      StOne: begin
        load_out  = accept & drain;
        load_skid = accept & ~drain;
      end
      StTwo:   move_skid = drain;
      default: ;
    endcase
    if (bus.flush) begin
      load_out  = 1'b0;
      load_skid = 1'b0;
      move_skid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_imm_q   <= '0;
      out_type_q  <= IMM_NONE;
      out_tag_q   <= '0;
      skid_imm_q  <= '0;
      skid_type_q <= IMM_NONE;
      skid_tag_q  <= '0;
    end else begin
      if (load_out) begin
        out_imm_q  <= dec_imm;
        out_type_q <= dec_type;
        out_tag_q  <= bus.in_tag;
      end else if (move_skid) begin
        out_imm_q  <= skid_imm_q;
        out_type_q <= skid_type_q;
        out_tag_q  <= skid_tag_q;
      end
      if (load_skid) begin
        skid_imm_q  <= dec_imm;
        skid_type_q <= dec_type;
        skid_tag_q  <= bus.in_tag;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state_q != StEmpty);
  assign bus.out_imm   = out_imm_q;
  assign bus.out_type  = out_type_q;
  assign bus.out_tag   = out_tag_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances driven in lockstep against a queue model.
module tb_imm_gen_pipe;
  import imm_pkg::*;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  typ;
    logic [31:0] tag;
  } ent_t;

  logic        clk, rst_n;
  logic        flush, in_valid, out_ready;
  logic [31:0] in_instr, in_tag;
  int          errors = 0;
  int          checks = 0;
  ent_t        q32[$];
  ent_t        q64[$];

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(32)) if32 ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(32)) if64 ();

  assign if32.flush = flush;      assign if64.flush = flush;
  assign if32.in_valid = in_valid; assign if64.in_valid = in_valid;
  assign if32.in_instr = in_instr; assign if64.in_instr = in_instr;
  assign if32.in_tag = in_tag;    assign if64.in_tag = in_tag;
  assign if32.out_ready = out_ready; assign if64.out_ready = out_ready;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));
  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) u_dut64 (.clk(clk), .rst_n(rst_n), .bus(if64));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Value semantics of each format, straight from the ISA definitions.
  function automatic ent_t model(input logic [31:0] ins, input int xlen, input logic [31:0] tag);
    ent_t   e;
    longint v;
    v     = 0;
    e.typ = IMM_NONE;
    case (ins[6:0])
      7'h03, 7'h13, 7'h67: begin v = longint'($signed(ins[31:20])); e.typ = IMM_I; end
      7'h1B: if (xlen == 64) begin v = longint'($signed(ins[31:20])); e.typ = IMM_I; end
      7'h23: begin v = longint'($signed({ins[31:25], ins[11:7]})); e.typ = IMM_S; end
      7'h63: begin
        v = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
        e.typ = IMM_B;
      end
      7'h37, 7'h17: begin v = longint'($signed({ins[31:12], 12'h000})); e.typ = IMM_U; end
      7'h6F: begin
        v = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
        e.typ = IMM_J;
      end
`ifdef IMM_CSR_EN
      7'h73: begin
        if (ins[14]) begin v = longint'(ins[19:15]); e.typ = IMM_Z; end
        else begin v = longint'($signed(ins[31:20])); e.typ = IMM_I; end
      end
`endif
      default: ;
    endcase
    e.imm = (xlen == 32) ? {32'h0, v[31:0]} : v;
    e.tag = tag;
    return e;
  endfunction

  always @(negedge rst_n) begin
    q32.delete();
    q64.delete();
  end

  always @(posedge clk) begin
    if (rst_n) begin
      bit acc32, drn32, acc64, drn64;
      acc32 = in_valid && (q32.size() < 2);
      drn32 = (q32.size() > 0) && out_ready;
      acc64 = in_valid && (q64.size() < 2);
      drn64 = (q64.size() > 0) && out_ready;
      if (flush) begin
        q32.delete();
        q64.delete();
      end else begin
        if (drn32) void'(q32.pop_front());
        if (acc32) q32.push_back(model(in_instr, 32, in_tag));
        if (drn64) void'(q64.pop_front());
        if (acc64) q64.push_back(model(in_instr, 64, in_tag));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_valid32", if32.out_valid, 0);
      chk("rst_ready32", if32.in_ready, 1);
      chk("rst_imm64", if64.out_imm, 0);
      chk("rst_tag64", if64.out_tag, 0);
    end else begin
      chk("cmp_valid32", if32.out_valid, q32.size() > 0);
      chk("cmp_ready32", if32.in_ready, q32.size() < 2);
      chk("cmp_valid64", if64.out_valid, q64.size() > 0);
      chk("cmp_ready64", if64.in_ready, q64.size() < 2);
      if (q32.size() > 0) begin
        chk("cmp_imm32", {32'h0, if32.out_imm}, q32[0].imm);
        chk("cmp_type32", if32.out_type, q32[0].typ);
        chk("cmp_tag32", if32.out_tag, q32[0].tag);
      end
      if (q64.size() > 0) begin
        chk("cmp_imm64", if64.out_imm, q64[0].imm);
        chk("cmp_type64", if64.out_type, q64[0].typ);
        chk("cmp_tag64", if64.out_tag, q64[0].tag);
      end
    end
  end

  task automatic drive(input logic [31:0] ins, input logic [31:0] tag);
    in_valid = 1'b1;
    in_instr = ins;
    in_tag   = tag;
  endtask

  logic [31:0] fmt_ins[4] = '{32'hFE112E23, 32'hFE000CE3, 32'h800000B7, 32'h0010006F};
  logic [63:0] fmt_imm[4] = '{64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFF8,
                              64'hFFFFFFFF80000000, 64'h0000000000000800};
  logic [2:0]  fmt_typ[4] = '{IMM_S, IMM_B, IMM_U, IMM_J};
  logic [31:0] mix_ins[8] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3, 32'h800000B7,
                              32'h0010006F, 32'hFFE0809B, 32'h300FD073, 32'h0000007F};

  initial begin
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_tag = '0; out_ready = 1'b1;
    #1 rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("reset_type32", if32.out_type, IMM_NONE);
    chk("reset_imm32", {32'h0, if32.out_imm}, 0);
    rst_n = 1'b1;

    drive(32'hFFF00093, 1);
    @(negedge clk);
    chk("addi_imm32", {32'h0, if32.out_imm}, 64'hFFFFFFFF);
    chk("addi_type32", if32.out_type, IMM_I);

    for (int i = 0; i < 4; i++) begin
      drive(fmt_ins[i], 10 + i);
      @(negedge clk);
      chk("fmt_imm64", if64.out_imm, fmt_imm[i]);
      chk("fmt_type64", if64.out_type, fmt_typ[i]);
    end

    drive(32'h0000007F, 20);
    @(negedge clk);
    chk("unk_imm32", {32'h0, if32.out_imm}, 0);
    chk("unk_type64", if64.out_type, IMM_NONE);

    drive(32'h300FD073, 21);
    @(negedge clk);
`ifdef IMM_CSR_EN
    chk("csr_imm64", if64.out_imm, 64'h1F);
    chk("csr_type64", if64.out_type, IMM_Z);
`else
    chk("csr_imm64", if64.out_imm, 0);
    chk("csr_type64", if64.out_type, IMM_NONE);
`endif
    in_valid = 1'b0;
    @(negedge clk);

    // Back-pressure: third input must wait while both entries are held.
    out_ready = 1'b0;
    drive(32'hFE112E23, 100); @(negedge clk);
    drive(32'h800000B7, 101); @(negedge clk);
    chk("bp_ready_low", if32.in_ready, 0);
    chk("bp_head", if32.out_tag, 100);
    drive(32'h0010006F, 102); @(negedge clk);
    chk("bp_ready_held", if64.in_ready, 0);
    chk("bp_stable_imm", if64.out_imm, 64'hFFFFFFFFFFFFFFFC);
    out_ready = 1'b1; @(negedge clk);
    chk("bp_drain1", if32.out_tag, 101);
    @(negedge clk);
    chk("bp_drain2", if32.out_tag, 102);
    in_valid = 1'b0; @(negedge clk);
    chk("bp_empty", if32.out_valid, 0);

    for (int k = 0; k < 8; k++) begin
      drive(mix_ins[k], 200 + k);
      @(negedge clk);
      chk("stream_valid", if64.out_valid, 1);
      chk("stream_tag", if64.out_tag, 200 + k);
    end
    in_valid = 1'b0; @(negedge clk);

    // Asynchronous reset with two entries held.
    out_ready = 1'b0;
    drive(32'hFFF00093, 300); @(negedge clk);
    drive(32'hFE000CE3, 301); @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", if32.out_valid, 0);
    chk("arst_ready", if64.in_ready, 1);
    @(negedge clk);
    chk("arst_hold_imm", if64.out_imm, 0);
    in_valid = 1'b0; out_ready = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);

    // Flush in TWO with a concurrent input.
    out_ready = 1'b0;
    drive(32'hFFF00093, 400); @(negedge clk);
    drive(32'hFE112E23, 401); @(negedge clk);
    drive(32'h800000B7, 402); flush = 1'b1; @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", if32.out_valid, 0);
    chk("flush_ready", if32.in_ready, 1);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Flush in ONE overriding simultaneous accept and drain.
    drive(32'hFE000CE3, 410); @(negedge clk);
    drive(32'h0010006F, 411); flush = 1'b1; @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush1_valid", if64.out_valid, 0);
    repeat (2) @(negedge clk);

    drive(32'hFFF00093, 500); @(negedge clk);
    chk("post_flush_tag", if32.out_tag, 500);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Registered, handshaked immediate generator for the decode stage of the pipelined core. Decodes the immediate of each RV32I/RV64I instruction, sign-extends it to `XLEN`, tags it with its format, and passes it through a 2-entry skid buffer. The skid buffer lets decode stall and flush without a combinational `ready` path. It sits between the IF/ID register and the ID/EX register and replaces the combinational generator in the pipelined build.

## Interface
- `XLEN`, 32: datapath width; only 32 and 64 are legal.
- `TAG_W`, 32: width of the sideband tag (PC) carried with each instruction.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `flush` input 1: synchronous kill of all buffered entries.
- `in_valid` input 1: `in_instr`/`in_tag` are valid.
- `in_ready` output 1: the block can accept an input this cycle. Registered.
- `in_instr` input 32: raw instruction word.
- `in_tag` input `TAG_W`: sideband tag.
- `out_valid` output 1: `out_*` fields are valid.
- `out_ready` input 1: the consumer accepts the output.
- `out_imm` output `XLEN`: extended immediate.
- `out_type` output 3: `imm_type_e` format code.
- `out_tag` output `TAG_W`: tag of the instruction on `out_imm`.

## Operation
- **Decode (combinational, input side), keyed on `in_instr[6:0]`:**
  - LOAD 0000011, OP-IMM 0010011, JALR 1100111 -> I-type.
  - STORE 0100011 -> S-type.
  - BRANCH 1100011 -> B-type, bit 0 = 0.
  - LUI 0110111, AUIPC 0010111 -> U-type: `{instr[31:12],12'b0}`, sign-extended from bit 31 when `XLEN=64`.
  - JAL 1101111 -> J-type, bit 0 = 0.
  - OP-IMM-32 0011011 -> I-type only when `XLEN=64`; otherwise NONE.
  - Any other opcode -> `out_imm`=0, `out_type`=IMM_NONE.
- **Sign extension:** the MSB of the assembled field (bit 11/11/12/31/20) replicates to `XLEN-1`.
- **Skid buffer:** two entries (output register + skid register). State machine `EMPTY`/`ONE`/`TWO`:
  - `EMPTY`: accept -> `ONE`.
  - `ONE`:
    - accept and no drain -> `TWO`; the new entry goes to skid.
    - accept and drain -> `ONE`; the new entry goes to the output register.
    - drain only -> `EMPTY`.
  - `TWO`: `in_ready`=0. Drain -> `ONE`; the skid entry moves to the output register.
- **Handshake:**
  - Accept = `in_valid & in_ready`. Drain = `out_valid & out_ready`.
  - Order is preserved. Output fields are stable while `out_valid & !out_ready`.
- **Flush:**
  - Next state is `EMPTY`. An input presented in the flush cycle is discarded.
  - `flush` overrides a simultaneous accept and drain.
  - `out_valid` is 0 the cycle after.
- **Reset:** mid-operation reset drops all entries asynchronously.

## Timing
- Latency: 1 cycle. An instruction accepted at edge N appears on `out_*` after edge N.
- Throughput: 1 per cycle while `out_ready`=1.
- `in_ready` is a flop, equal to (next state != `TWO`). It does not depend combinationally on `out_ready`.
- Reset values:
  - `out_valid`=0, `out_imm`=0, `out_type`=IMM_NONE, `out_tag`=0.
  - `in_ready`=1, state `EMPTY`.
  - Skid contents=0.
- No output changes while the block is held in reset.

## Configuration
- `IMM_CSR_EN` defined:
  - SYSTEM opcode 1110011 with `funct3[2]`=1 (CSRRWI/CSRRSI/CSRRCI) -> `out_type`=IMM_Z.
  - `out_imm` = `instr[19:15]` zero-extended.
  - Other SYSTEM encodings -> I-type, which carries the CSR address/funct12.
- `IMM_CSR_EN` undefined: SYSTEM -> IMM_NONE, `out_imm`=0. IMM_Z is never produced.

## Structure
- **Package `imm_pkg`:**
  - `imm_type_e` (3 bits): IMM_NONE=0, IMM_I=1, IMM_S=2, IMM_B=3, IMM_U=4, IMM_J=5, IMM_Z=6.
  - Opcode localparams: OPC_LOAD, OPC_OPIMM, OPC_OPIMM32, OPC_JALR, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_SYSTEM.
  - State enum `skid_st_e`.
- **Sub-module `imm_decode`:** purely combinational, `XLEN` parameter, instruction in, `{imm,type}` out. It is instantiated once on the input side, so only decoded data is buffered.

## Test plan
- **Reset and I-type:**
  - Assert `rst_n`=0 mid-stream -> `out_valid`=0 and `in_ready`=1 immediately.
  - After release, `addi x1,x0,-1` (0xFFF00093), `XLEN=32` -> next cycle `out_imm`=0xFFFFFFFF, `out_type`=IMM_I.
- **All formats at `XLEN=64`:**
  - `sw` imm -4 (0xFE112E23) -> 0xFFFFFFFFFFFFFFFC, IMM_S.
  - `beq` imm -8 (0xFE000CE3) -> ...FFF8, IMM_B.
  - `lui` 0x80000 (0x800000B7) -> 0xFFFFFFFF80000000, IMM_U.
  - `jal` +2048 (0x0010006F) -> 0x800, IMM_J.
- **Back-pressure:**
  - Hold `out_ready`=0 and send 3 instructions -> 2 accepted, `in_ready`=0 from the cycle after the second accept, output held stable.
  - Release `out_ready` -> entries drain in order.
- **Streaming:** `out_ready`=1 and 8 back-to-back inputs -> 8 outputs on 8 consecutive cycles, tags match input order.
- **Flush:** assert `flush` in state `TWO` together with `in_valid` -> next cycle `out_valid`=0, `in_ready`=1, and neither the flushed nor the concurrent input ever appears.
- **Config:**
  - With `IMM_CSR_EN`: `csrrwi x0,mstatus,31` (0x300FD073) -> `out_imm`=0x1F, IMM_Z.
  - Without it: the same instruction -> 0, IMM_NONE.
  - Unknown opcode 0x0000007F -> 0, IMM_NONE in both builds.
